// File: rtl/idex_pipe_reg_pkg.sv
// idex_pipe_reg_pkg: shared helpers for the ID/EX pipeline register
package idex_pipe_reg_pkg;

    localparam int MAX_THREADS = 64;
    localparam int MAX_TID_W   = $clog2(MAX_THREADS);

    function automatic logic flush_hit(input logic [MAX_THREADS-1:0] mask,
                                       input logic [MAX_TID_W-1:0]   tid);
        return mask[tid];
    endfunction

endpackage

// File: rtl/idex_pipe_reg_slot.sv
// idex_pipe_reg_slot: one payload register plus valid bit with load/clear
module idex_pipe_reg_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_valid
);

    logic [W-1:0] r_q;
    logic         r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX register with valid/ready handshake, 2-entry skid buffer,
// per-thread squash, bubble sanitising and a saturating stall counter
module idex_pipe_reg
    import idex_pipe_reg_pkg::*;
#(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5,
    parameter int INSTMEM_LOG2_DEEP      = 8,
    parameter int NUM_THREADS            = 4,
    parameter int STALL_CNT_W            = 16,
    localparam int TID_W                 = $clog2(NUM_THREADS)
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              WRegEn_in,
    input  logic                              WMemEn_in,
    input  logic                              alu_src_in,
    input  logic                              mem_to_reg_in,
    input  logic                              func7_in,
    input  logic [PROC_DATA_WIDTH-1:0]        R1out_in,
    input  logic [PROC_DATA_WIDTH-1:0]        R2out_in,
    input  logic [PROC_DATA_WIDTH-1:0]        sign_ext_in,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_in,
    input  logic [2:0]                        func3_in,
    input  logic [TID_W-1:0]                  thread_id_in,
    input  logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_i,
    input  logic [NUM_THREADS-1:0]            flush_mask,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              WRegEn_out,
    output logic                              WMemEn_out,
    output logic                              alu_src_out,
    output logic                              mem_to_reg_out,
    output logic                              func7_out,
    output logic [PROC_DATA_WIDTH-1:0]        R1out_out,
    output logic [PROC_DATA_WIDTH-1:0]        R2out_out,
    output logic [PROC_DATA_WIDTH-1:0]        sign_ext_out,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_out,
    output logic [2:0]                        func3_out,
    output logic [TID_W-1:0]                  thread_id_out,
    output logic [INSTMEM_LOG2_DEEP-1:0]      pc_carry_baggage_o,
    input  logic                              stall_cnt_clr,
    output logic [STALL_CNT_W-1:0]            stall_cnt
);

    typedef struct packed {
        logic                              wreg_en;
        logic                              wmem_en;
        logic                              alu_src;
        logic                              mem_to_reg;
        logic                              func7;
        logic [PROC_DATA_WIDTH-1:0]        r1;
        logic [PROC_DATA_WIDTH-1:0]        r2;
        logic [PROC_DATA_WIDTH-1:0]        imm;
        logic [PROC_REGFILE_LOG2_DEEP-1:0] wreg1;
        logic [2:0]                        func3;
        logic [TID_W-1:0]                  tid;
        logic [INSTMEM_LOG2_DEEP-1:0]      pc;
    } idex_payload_t;

    idex_payload_t          w_in_pl, w_m_q, w_s_q, w_m_d;
    logic                   w_m_valid, w_s_valid;
    logic                   w_in_fire, w_out_fire, w_m_surv, w_s_surv, w_s_to_m;
    logic                   w_m_load, w_m_clr, w_s_load, w_s_clr, w_s_next;
    logic                   r_in_ready;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_in_pl = '{wreg_en: WRegEn_in, wmem_en: WMemEn_in, alu_src: alu_src_in,
                       mem_to_reg: mem_to_reg_in, func7: func7_in, r1: R1out_in,
                       r2: R2out_in, imm: sign_ext_in, wreg1: WReg1_in, func3: func3_in,
                       tid: thread_id_in, pc: pc_carry_baggage_i};

    assign w_in_fire  = in_valid & r_in_ready & ~flush_hit(64'(flush_mask), 6'(thread_id_in));
    assign w_out_fire = w_m_valid & out_ready;
    assign w_m_surv   = w_m_valid & ~w_out_fire & ~flush_hit(64'(flush_mask), 6'(w_m_q.tid));
    assign w_s_surv   = w_s_valid & ~flush_hit(64'(flush_mask), 6'(w_s_q.tid));
    assign w_s_to_m   = ~w_m_surv & w_s_surv;

    // M refills from S first (older), otherwise from the input; S takes the input only behind a live M
    assign w_m_load = w_s_to_m | (~w_m_surv & ~w_s_surv & w_in_fire);
    assign w_m_clr  = ~w_m_surv;
    assign w_m_d    = w_s_to_m ? w_s_q : w_in_pl;
    assign w_s_load = w_in_fire & (w_m_surv | w_s_surv);
    assign w_s_clr  = ~w_s_surv | ~w_m_surv;
    assign w_s_next = w_s_load | (w_s_surv & w_m_surv);

    idex_pipe_reg_slot #(.W($bits(idex_payload_t))) u_slot_m (
        .clk(CLK), .rst_n(RST_N), .i_load(w_m_load), .i_clr(w_m_clr),
        .i_d(w_m_d), .o_q(w_m_q), .o_valid(w_m_valid)
    );

    idex_pipe_reg_slot #(.W($bits(idex_payload_t))) u_slot_s (
        .clk(CLK), .rst_n(RST_N), .i_load(w_s_load), .i_clr(w_s_clr),
        .i_d(w_in_pl), .o_q(w_s_q), .o_valid(w_s_valid)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_in_ready  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_in_ready  <= ~w_s_next;
            r_stall_cnt <= stall_cnt_clr ? '0 :
                           (w_m_valid & ~out_ready & ~&r_stall_cnt) ? r_stall_cnt + 1'b1 :
                           r_stall_cnt;
        end
    end

    assign in_ready           = r_in_ready;
    assign stall_cnt          = r_stall_cnt;
    assign out_valid          = w_m_valid;
    assign WRegEn_out         = w_m_q.wreg_en & w_m_valid;
    assign WMemEn_out         = w_m_q.wmem_en & w_m_valid;
    assign alu_src_out        = w_m_q.alu_src;
    assign mem_to_reg_out     = w_m_q.mem_to_reg;
    assign func7_out          = w_m_q.func7;
    assign R1out_out          = w_m_q.r1;
    assign R2out_out          = w_m_q.r2;
    assign sign_ext_out       = w_m_q.imm;
    assign WReg1_out          = w_m_q.wreg1;
    assign func3_out          = w_m_q.func3;
    assign thread_id_out      = w_m_q.tid;
    assign pc_carry_baggage_o = w_m_q.pc;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed self-checking bench for idex_pipe_reg
module tb_idex_pipe_reg;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        WRegEn_in, WMemEn_in, alu_src_in, mem_to_reg_in, func7_in;
    logic        WRegEn_out, WMemEn_out, alu_src_out, mem_to_reg_out, func7_out;
    logic [15:0] R1out_in, R2out_in, sign_ext_in, R1out_out, R2out_out, sign_ext_out;
    logic [4:0]  WReg1_in, WReg1_out;
    logic [2:0]  func3_in, func3_out;
    logic [1:0]  thread_id_in, thread_id_out;
    logic [7:0]  pc_carry_baggage_i, pc_carry_baggage_o;
    logic [3:0]  flush_mask;
    logic        stall_cnt_clr;
    logic [3:0]  stall_cnt;

    int compared = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    idex_pipe_reg #(.STALL_CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
        .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in), .alu_src_in(alu_src_in),
        .mem_to_reg_in(mem_to_reg_in), .func7_in(func7_in), .R1out_in(R1out_in),
        .R2out_in(R2out_in), .sign_ext_in(sign_ext_in), .WReg1_in(WReg1_in),
        .func3_in(func3_in), .thread_id_in(thread_id_in),
        .pc_carry_baggage_i(pc_carry_baggage_i), .flush_mask(flush_mask),
        .out_valid(out_valid), .out_ready(out_ready), .WRegEn_out(WRegEn_out),
        .WMemEn_out(WMemEn_out), .alu_src_out(alu_src_out), .mem_to_reg_out(mem_to_reg_out),
        .func7_out(func7_out), .R1out_out(R1out_out), .R2out_out(R2out_out),
        .sign_ext_out(sign_ext_out), .WReg1_out(WReg1_out), .func3_out(func3_out),
        .thread_id_out(thread_id_out), .pc_carry_baggage_o(pc_carry_baggage_o),
        .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic v, input logic [1:0] tid, input logic [15:0] r1);
        in_valid           = v;
        thread_id_in       = tid;
        R1out_in           = r1;
        R2out_in           = ~r1;
        sign_ext_in        = r1 ^ 16'h5a5a;
        pc_carry_baggage_i = r1[7:0];
        WReg1_in           = r1[4:0];
        func3_in           = r1[2:0];
        WRegEn_in          = 1'b1;
        WMemEn_in          = 1'b1;
        alu_src_in         = r1[0];
        mem_to_reg_in      = r1[1];
        func7_in           = r1[2];
    endtask

    initial begin
        RST_N = 1'b0;
        out_ready = 1'b0;
        flush_mask = '0;
        stall_cnt_clr = 1'b0;
        put(1'b0, 2'd0, 16'h0000);
        WRegEn_in = 1'b0;
        WMemEn_in = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r1", 32'(R1out_out), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_wregen", 32'(WRegEn_out), 32'd0);
        #1 RST_N = 1'b1;
        #1 chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        put(1'b1, 2'd2, 16'h1234);
        tick();
        put(1'b0, 2'd0, 16'h0000);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_r1", 32'(R1out_out), 32'h1234);
        chk("single_r2", 32'(R2out_out), 32'hedcb);
        chk("single_imm", 32'(sign_ext_out), 32'h486e);
        chk("single_tid", 32'(thread_id_out), 32'd2);
        chk("single_pc", 32'(pc_carry_baggage_o), 32'h34);
        chk("single_wregen", 32'(WRegEn_out), 32'd1);
        tick();
        chk("bubble_valid", 32'(out_valid), 32'd0);
        chk("bubble_wregen", 32'(WRegEn_out), 32'd0);
        chk("bubble_wmemen", 32'(WMemEn_out), 32'd0);

        out_ready = 1'b0;
        put(1'b1, 2'd0, 16'haaaa);
        tick();
        chk("bp_a_r1", 32'(R1out_out), 32'haaaa);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        chk("bp_stall0", 32'(stall_cnt), 32'd0);
        put(1'b1, 2'd1, 16'hbbbb);
        tick();
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_still_a", 32'(R1out_out), 32'haaaa);
        chk("bp_stall1", 32'(stall_cnt), 32'd1);
        put(1'b1, 2'd2, 16'hcccc);
        tick();
        chk("bp_stall2", 32'(stall_cnt), 32'd2);
        chk("bp_full_ready2", 32'(in_ready), 32'd0);
        put(1'b0, 2'd0, 16'h0000);
        tick();
        chk("bp_stall3", 32'(stall_cnt), 32'd3);
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_r1", 32'(R1out_out), 32'hbbbb);
        chk("bp_b_tid", 32'(thread_id_out), 32'd1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_stall_hold", 32'(stall_cnt), 32'd3);
        tick();
        chk("bp_c_dropped", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        put(1'b1, 2'd1, 16'h1111);
        tick();
        put(1'b1, 2'd3, 16'h3333);
        tick();
        put(1'b0, 2'd0, 16'h0000);
        chk("fl_full", 32'(in_ready), 32'd0);
        flush_mask = 4'b0010;
        tick();
        flush_mask = 4'b0000;
        chk("fl_valid", 32'(out_valid), 32'd1);
        chk("fl_tid", 32'(thread_id_out), 32'd3);
        chk("fl_r1", 32'(R1out_out), 32'h3333);
        chk("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_drained", 32'(out_valid), 32'd0);

        put(1'b1, 2'd0, 16'h7777);
        flush_mask = 4'b0001;
        tick();
        put(1'b0, 2'd0, 16'h0000);
        flush_mask = 4'b0000;
        chk("sq_valid", 32'(out_valid), 32'd0);
        chk("sq_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b0;
        put(1'b1, 2'd2, 16'h2222);
        tick();
        put(1'b1, 2'd0, 16'h0f0f);
        tick();
        put(1'b0, 2'd0, 16'h0000);
        out_ready = 1'b1;
        flush_mask = 4'b0100;
        tick();
        flush_mask = 4'b0000;
        chk("ff_next_valid", 32'(out_valid), 32'd1);
        chk("ff_next_r1", 32'(R1out_out), 32'h0f0f);
        chk("ff_next_tid", 32'(thread_id_out), 32'd0);
        tick();
        chk("ff_empty", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        put(1'b1, 2'd1, 16'h5555);
        tick();
        put(1'b1, 2'd2, 16'h6666);
        tick();
        put(1'b0, 2'd0, 16'h0000);
        flush_mask = 4'b1111;
        tick();
        flush_mask = 4'b0000;
        chk("fa_valid", 32'(out_valid), 32'd0);
        chk("fa_ready", 32'(in_ready), 32'd1);

        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        chk("clr_stall", 32'(stall_cnt), 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            put(1'b1, 2'(i), 16'(i + 16'h100));
            tick();
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_r1", 32'(R1out_out), 32'(i + 16'h100));
            chk("st_ready", 32'(in_ready), 32'd1);
        end
        put(1'b0, 2'd0, 16'h0000);
        tick();
        chk("st_end", 32'(out_valid), 32'd0);
        chk("st_stall", 32'(stall_cnt), 32'd0);

        out_ready = 1'b0;
        put(1'b1, 2'd3, 16'h9999);
        tick();
        put(1'b0, 2'd0, 16'h0000);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(stall_cnt), 32'd15);
        stall_cnt_clr = 1'b1;
        tick();
        stall_cnt_clr = 1'b0;
        chk("sat_clr", 32'(stall_cnt), 32'd0);

        put(1'b1, 2'd1, 16'h4444);
        tick();
        put(1'b0, 2'd0, 16'h0000);
        chk("rm_full", 32'(in_ready), 32'd0);
        #2 RST_N = 1'b0;
        #1;
        chk("rm_valid", 32'(out_valid), 32'd0);
        chk("rm_r1", 32'(R1out_out), 32'd0);
        chk("rm_tid", 32'(thread_id_out), 32'd0);
        chk("rm_pc", 32'(pc_carry_baggage_o), 32'd0);
        chk("rm_ready", 32'(in_ready), 32'd0);
        chk("rm_stall", 32'(stall_cnt), 32'd0);
        RST_N = 1'b1;
        tick();
        chk("rm_ready_back", 32'(in_ready), 32'd1);
        chk("rm_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
